smpc_intback_scan: RTL and testbench

Parametrised peripheral-scan engine for the SMPC INTBACK path. On a start request it snapshots the pad inputs of NPORTS ports and serialises them into an OREG-style byte buffer, one port entry at a time. When the next entry does not fit in the buffer, it stops and raises IRQ, then waits for a host CONTINUE or BREAK. This generalises the fixed single-pad, single-block peripheral report to N ports, any buffer depth and multi-block transfers.

---
 rtl/smpc_pkg.sv | 42 ++++
 rtl/smpc_oreg_ram.sv | 48 ++++
 rtl/smpc_intback_scan.sv | 170 +++++++++++++++++
 tb/tb_smpc_intback_scan.sv | 348 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/smpc_pkg.sv
// smpc_pkg: shared types and constants for the SMPC INTBACK scan path.
// Holds the scan FSM encoding and the OREG peripheral report bytes.
package smpc_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_FILL,
    S_BEND,
    S_WAIT
  } state_e;

  localparam logic [7:0] PST_CONN       = 8'hF1;
  localparam logic [7:0] PST_NONE       = 8'hF0;
  localparam logic [7:0] PAD_ID_DIGITAL = 8'h02;

  localparam logic [2:0] LEN_CONN = 3'd4;
  localparam logic [2:0] LEN_NONE = 3'd1;

  function automatic logic [2:0] entry_len(
    input logic conn
  );
    return conn ? LEN_CONN : LEN_NONE;
  endfunction

  // Byte idx of one port entry; idx>0 only occurs for connected ports.
  function automatic logic [7:0] entry_byte(
    input logic        conn,
    input logic [15:0] pad,
    input logic [1:0]  idx
  );
    logic [7:0] b;
    unique case (idx)
      2'd0:    b = conn ? PST_CONN : PST_NONE;
      2'd1:    b = PAD_ID_DIGITAL;
      2'd2:    b = pad[15:8];
      default: b = pad[7:0];
    endcase
    return b;
  endfunction

endpackage

// File: rtl/smpc_oreg_ram.sv
// smpc_oreg_ram: DEPTH x 8 OREG buffer, one write port, one registered read.
// Contents clear on reset so a host never sees stale report bytes.
module smpc_oreg_ram #(
  parameter int DEPTH = 32,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          CLK,
  input  logic          RST_N,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [7:0]    wdata_i,
  input  logic [AW-1:0] raddr_i,
  output logic [7:0]    rdata_o
);

  logic [7:0] mem_q [DEPTH];
  logic [7:0] rdata_q;
  logic [7:0] rdata_d;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= 8'h00;
      end
    end else if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  // Addresses past DEPTH (non power-of-two depths) read as zero.
  always_comb begin
    rdata_d = 8'h00;
    if (int'(raddr_i) < DEPTH) begin
      rdata_d = mem_q[raddr_i];
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      rdata_q <= 8'h00;
    end else begin
      rdata_q <= rdata_d;
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/smpc_intback_scan.sv
// smpc_intback_scan: INTBACK peripheral scan of NPORTS pads into OREG.
// Fills the buffer in whole-entry blocks, raising IRQ at each block end.
module smpc_intback_scan
  import smpc_pkg::*;
#(
  parameter int NPORTS = 2,
  parameter int DEPTH  = 32
) (
  input  logic                       CLK,
  input  logic                       RST_N,
  input  logic                       CE,
  input  logic                       START,
  input  logic                       CONT,
  input  logic                       BREAK,
  input  logic [NPORTS-1:0]          PORT_EN,
  input  logic [16*NPORTS-1:0]       JOY,
  input  logic [$clog2(DEPTH)-1:0]   RADDR,
  output logic [7:0]                 RDATA,
  output logic                       BUSY,
  output logic                       IRQ,
  output logic                       MORE
);

  localparam int PW = $clog2(NPORTS + 1);
  localparam int WW = $clog2(DEPTH + 1);
  localparam int AW = $clog2(DEPTH);

  state_e               state_q;
  logic [PW-1:0]        pidx_q;
  logic [WW-1:0]        wptr_q;
  logic [1:0]           bidx_q;
  logic [NPORTS-1:0]    en_q;
  logic [16*NPORTS-1:0] joy_q;
  logic                 busy_q;
  logic                 irq_q;
  logic                 more_q;

  logic                 cur_conn;
  logic                 nxt_conn;
  logic [15:0]          cur_joy;
  logic                 last_byte;
  logic                 nxt_end;
  logic                 nxt_full;
  logic [WW:0]          room;
  logic                 we;
  logic [7:0]           wdata;

  // Current entry's port, and the port whose entry would follow it.
  always_comb begin
    cur_conn = 1'b0;
    cur_joy  = 16'h0000;
    nxt_conn = 1'b0;
    for (int p = 0; p < NPORTS; p++) begin
      if (pidx_q == PW'(p)) begin
        cur_conn = en_q[p];
        cur_joy  = joy_q[16*p +: 16];
      end
      if (p > 0 && pidx_q == PW'(p - 1)) begin
        nxt_conn = en_q[p];
      end
    end
  end

  always_comb begin
    last_byte = (bidx_q == (cur_conn ? 2'd3 : 2'd0));
    nxt_end   = (pidx_q == PW'(NPORTS - 1));
    room      = (WW+1)'(DEPTH - 1) - {1'b0, wptr_q};
    nxt_full  = ((WW+1)'(entry_len(nxt_conn)) > room);
  end

  always_comb begin
    we    = 1'b0;
    wdata = 8'h00;
    unique case (1'b1)
      (state_q == S_CLEAR): we = CE;
      (state_q == S_FILL): begin
        we    = CE;
        wdata = entry_byte(cur_conn, cur_joy, bidx_q);
      end
      default: we = 1'b0;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= S_IDLE;
      pidx_q  <= '0;
      wptr_q  <= '0;
      bidx_q  <= 2'd0;
      en_q    <= '0;
      joy_q   <= '0;
      busy_q  <= 1'b0;
      irq_q   <= 1'b0;
      more_q  <= 1'b0;
    end else begin
      irq_q <= 1'b0;
      if (CE) begin
        unique case (state_q)
          S_IDLE: begin
            if (START) begin
              en_q    <= PORT_EN;
              joy_q   <= JOY;
              pidx_q  <= '0;
              wptr_q  <= '0;
              busy_q  <= 1'b1;
              state_q <= S_CLEAR;
            end
          end
          S_CLEAR: begin
            if (wptr_q == WW'(DEPTH - 1)) begin
              wptr_q  <= '0;
              bidx_q  <= 2'd0;
              state_q <= S_FILL;
            end else begin
              wptr_q <= wptr_q + WW'(1);
            end
          end
          S_FILL: begin
            wptr_q <= wptr_q + WW'(1);
            if (last_byte) begin
              bidx_q <= 2'd0;
              pidx_q <= pidx_q + PW'(1);
              // Decide at the entry boundary so BEND follows the last byte.
              if (nxt_end || nxt_full) begin
                irq_q   <= 1'b1;
                more_q  <= !nxt_end;
                state_q <= S_BEND;
              end
            end else begin
              bidx_q <= bidx_q + 2'd1;
            end
          end
          S_BEND: begin
            busy_q  <= 1'b0;
            state_q <= more_q ? S_WAIT : S_IDLE;
          end
          S_WAIT: begin
            if (BREAK) begin
              more_q  <= 1'b0;
              state_q <= S_IDLE;
            end else if (CONT) begin
              more_q  <= 1'b0;
              wptr_q  <= '0;
              busy_q  <= 1'b1;
              state_q <= S_CLEAR;
            end
          end
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

  smpc_oreg_ram #(
    .DEPTH (DEPTH)
  ) u_oreg (
    .CLK     (CLK),
    .RST_N   (RST_N),
    .we_i    (we),
    .waddr_i (wptr_q[AW-1:0]),
    .wdata_i (wdata),
    .raddr_i (RADDR),
    .rdata_o (RDATA)
  );

  assign BUSY = busy_q;
  assign IRQ  = irq_q;
  assign MORE = more_q;

endmodule

// File: tb/tb_smpc_intback_scan.sv
// tb_smpc_intback_scan: checks two configurations of the INTBACK scan
// engine (2 ports/32 bytes and 3 ports/4 bytes) against a block model.
module tb_smpc_intback_scan;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ce;
  logic        start;
  logic        cont;
  logic        brk;
  logic        sel;
  logic [2:0]  port_en;
  logic [47:0] joy;
  logic [4:0]  raddr;

  logic [7:0]  a_rdata, b_rdata, rdata;
  logic        a_busy, b_busy, busy;
  logic        a_irq, b_irq, irq;
  logic        a_more, b_more, more;

  int nchk = 0;
  int nerr = 0;
  logic [7:0] exp_buf [32];

  typedef struct {
    logic        sel;
    logic [2:0]  en;
    logic [47:0] joy;
    int          irq_at;
    logic        more;
    logic [63:0] b;
  } vec_t;

  vec_t vt [8];

  always #5 clk = ~clk;

  assign rdata = sel ? b_rdata : a_rdata;
  assign busy  = sel ? b_busy  : a_busy;
  assign irq   = sel ? b_irq   : a_irq;
  assign more  = sel ? b_more  : a_more;

  smpc_intback_scan u_a (
    .CLK     (clk),
    .RST_N   (rst_n),
    .CE      (ce),
    .START   (start & ~sel),
    .CONT    (cont & ~sel),
    .BREAK   (brk & ~sel),
    .PORT_EN (port_en[1:0]),
    .JOY     (joy[31:0]),
    .RADDR   (raddr[4:0]),
    .RDATA   (a_rdata),
    .BUSY    (a_busy),
    .IRQ     (a_irq),
    .MORE    (a_more)
  );

  smpc_intback_scan #(
    .NPORTS (3),
    .DEPTH  (4)
  ) u_b (
    .CLK     (clk),
    .RST_N   (rst_n),
    .CE      (ce),
    .START   (start & sel),
    .CONT    (cont & sel),
    .BREAK   (brk & sel),
    .PORT_EN (port_en),
    .JOY     (joy),
    .RADDR   (raddr[1:0]),
    .RDATA   (b_rdata),
    .BUSY    (b_busy),
    .IRQ     (b_irq),
    .MORE    (b_more)
  );

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  // Greedy packing of whole entries, starting at port p0.
  task automatic model_block(input int np, input int dp,
                             input logic [2:0] en, input logic [47:0] jy,
                             input int p0, output int nb, output bit mr,
                             output int p1);
    int len;
    nb = 0;
    mr = 1'b0;
    p1 = p0;
    for (int i = 0; i < 32; i++) exp_buf[i] = 8'h00;
    while (p1 < np) begin
      len = en[p1] ? 4 : 1;
      if (nb + len > dp) begin
        mr = 1'b1;
        break;
      end
      if (en[p1]) begin
        exp_buf[nb]     = 8'hF1;
        exp_buf[nb + 1] = 8'h02;
        exp_buf[nb + 2] = jy[16*p1 + 8 +: 8];
        exp_buf[nb + 3] = jy[16*p1 +: 8];
      end else begin
        exp_buf[nb] = 8'hF0;
      end
      nb += len;
      p1++;
    end
  endtask

  task automatic step();
    ce = 1'b1;
    @(posedge clk);
    @(negedge clk);
  endtask

  // kind: 0 START, 1 CONT, 2 BREAK, 3 CONT+BREAK
  task automatic pulse(input int kind);
    ce    = 1'b1;
    start = (kind == 0);
    cont  = (kind == 1 || kind == 3);
    brk   = (kind == 2 || kind == 3);
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    cont  = 1'b0;
    brk   = 1'b0;
  endtask

  // k is the CE-cycle number (accept cycle = 0) on which IRQ is seen.
  task automatic wait_irq(input bit tgl, input bit hook,
                          output int k, output bit ok);
    int bad;
    bad = 0;
    k   = 1;
    ok  = 1'b0;
    for (int n = 0; n < 400 && !ok; n++) begin
      ce = tgl ? ~ce : 1'b1;
      @(posedge clk);
      if (ce) k++;
      @(negedge clk);
      if (!busy) bad++;
      if (irq) ok = 1'b1;
      if (hook && k == 2 && !start) begin
        start   = 1'b1;
        joy     = ~joy;
        port_en = ~port_en;
      end else if (hook && k >= 3) begin
        start = 1'b0;
      end
    end
    start = 1'b0;
    ce    = 1'b1;
    chk("busy_run", bad, 0);
  endtask

  task automatic check_buf(input int dp, input string tag);
    for (int i = 0; i < dp; i++) begin
      raddr = 5'(i);
      @(posedge clk);
      @(negedge clk);
      chk($sformatf("%s_buf[%0d]", tag, i), rdata, exp_buf[i]);
    end
  endtask

  task automatic run_scan(input bit tgl, input bit hook);
    int p, nb, p1, k, np, dp, blk;
    bit mr, ok;
    logic [2:0] en0;
    logic [47:0] jy0;
    np  = sel ? 3 : 2;
    dp  = sel ? 4 : 32;
    en0 = port_en;
    jy0 = joy;
    p   = 0;
    blk = 0;
    pulse(0);
    chk("busy_start", busy, 1);
    forever begin
      model_block(np, dp, en0, jy0, p, nb, mr, p1);
      wait_irq(tgl, hook && p == 0, k, ok);
      chk("irq_seen", ok, 1);
      if (!ok) break;
      chk($sformatf("irq_cycle_b%0d", blk), k, dp + nb + 1);
      chk("more_at_irq", more, mr);
      step();
      chk("busy_after", busy, 0);
      chk("irq_pulse", irq, 0);
      chk("more_after", more, mr);
      check_buf(dp, $sformatf("scan_b%0d", blk));
      if (!mr) break;
      p = p1;
      blk++;
      pulse(1);
      chk("busy_cont", busy, 1);
      chk("more_cont", more, 0);
    end
  endtask

  initial begin
    int k, dp, cnt;
    bit ok;
    logic [63:0] bb;
    logic [7:0] eb;

    vt[0] = '{sel: 1'b0, en: 3'b011, joy: 48'h0000_7FFF_FFF7,
              irq_at: 41, more: 1'b0, b: 64'hF102FFF7F1027FFF};
    vt[1] = '{sel: 1'b0, en: 3'b001, joy: 48'h0000_7FFF_FFF7,
              irq_at: 38, more: 1'b0, b: 64'hF102FFF7F0000000};
    vt[2] = '{sel: 1'b0, en: 3'b000, joy: 48'h0000_7FFF_FFF7,
              irq_at: 35, more: 1'b0, b: 64'hF0F0000000000000};
    vt[3] = '{sel: 1'b0, en: 3'b010, joy: 48'h0000_1234_ABCD,
              irq_at: 38, more: 1'b0, b: 64'hF0F1021234000000};
    vt[4] = '{sel: 1'b1, en: 3'b111, joy: 48'h5555_AAAA_0F0F,
              irq_at: 9, more: 1'b1, b: 64'hF1020F0F00000000};
    vt[5] = '{sel: 1'b1, en: 3'b000, joy: 48'h5555_AAAA_0F0F,
              irq_at: 8, more: 1'b0, b: 64'hF0F0F00000000000};
    vt[6] = '{sel: 1'b1, en: 3'b010, joy: 48'h5555_AAAA_0F0F,
              irq_at: 6, more: 1'b1, b: 64'hF000000000000000};
    vt[7] = '{sel: 1'b1, en: 3'b101, joy: 48'h5555_AAAA_0F0F,
              irq_at: 9, more: 1'b1, b: 64'hF1020F0F00000000};

    rst_n   = 1'b0;
    ce      = 1'b0;
    start   = 1'b0;
    cont    = 1'b0;
    brk     = 1'b0;
    sel     = 1'b0;
    port_en = 3'b000;
    joy     = 48'h0;
    raddr   = 5'd0;
    repeat (2) @(negedge clk);
    for (int s = 0; s < 2; s++) begin
      sel = s[0];
      #1;
      chk("rst_busy", busy, 0);
      chk("rst_irq", irq, 0);
      chk("rst_more", more, 0);
      chk("rst_rdata", rdata, 0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    sel   = 1'b1;
    for (int i = 0; i < 32; i++) exp_buf[i] = 8'h00;
    check_buf(4, "rst");

    // Table: first block of each pattern
    for (int v = 0; v < 8; v++) begin
      sel     = vt[v].sel;
      port_en = vt[v].en;
      joy     = vt[v].joy;
      dp      = sel ? 4 : 32;
      pulse(0);
      wait_irq(1'b0, 1'b0, k, ok);
      chk($sformatf("vec%0d_irq_seen", v), ok, 1);
      chk($sformatf("vec%0d_irq_cycle", v), k, vt[v].irq_at);
      chk($sformatf("vec%0d_more", v), more, vt[v].more);
      step();
      bb = vt[v].b;
      for (int i = 0; i < 32; i++) begin
        eb = (i < 8) ? bb[63-8*i -: 8] : 8'h00;
        exp_buf[i] = eb;
      end
      check_buf(dp, $sformatf("vec%0d", v));
      if (vt[v].more) begin
        pulse(2);
        chk($sformatf("vec%0d_brk_more", v), more, 0);
        chk($sformatf("vec%0d_brk_busy", v), busy, 0);
      end
    end

    // Three blocks, one port each, via CONT
    sel     = 1'b1;
    port_en = 3'b111;
    joy     = 48'hBEEF_C0DE_F00D;
    run_scan(1'b0, 1'b0);

    // CONT and BREAK together: BREAK wins, then a fresh scan
    pulse(0);
    wait_irq(1'b0, 1'b0, k, ok);
    chk("cb_irq_seen", ok, 1);
    step();
    chk("cb_more_wait", more, 1);
    pulse(3);
    chk("cb_more", more, 0);
    chk("cb_busy", busy, 0);
    cnt = 0;
    repeat (40) begin
      step();
      if (irq || busy) cnt++;
    end
    chk("cb_quiet", cnt, 0);
    joy = 48'h1357_9BDF_2468;
    run_scan(1'b0, 1'b0);

    // Snapshot holds across blocks; START while busy is ignored
    port_en = 3'b111;
    joy     = 48'h1111_2222_3333;
    run_scan(1'b0, 1'b1);
    sel     = 1'b0;
    port_en = 3'b011;
    joy     = 48'h0000_4321_8765;
    run_scan(1'b0, 1'b1);

    // CE toggling gives the same CE-cycle count and contents
    port_en = 3'b011;
    joy     = 48'h0000_7FFF_FFF7;
    run_scan(1'b1, 1'b0);
    sel = 1'b1;
    port_en = 3'b111;
    run_scan(1'b1, 1'b0);

    for (int r = 0; r < 10; r++) begin
      sel     = 1'($urandom_range(0, 1));
      port_en = 3'($urandom);
      joy     = {16'($urandom), 32'($urandom)};
      run_scan(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    // Reset in the middle of FILL
    sel     = 1'b0;
    port_en = 3'b011;
    joy     = 48'h0000_7FFF_FFF7;
    pulse(0);
    repeat (36) step();
    chk("mid_busy", busy, 1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_irq", irq, 0);
    chk("mid_rst_more", more, 0);
    chk("mid_rst_rdata", rdata, 0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 32; i++) exp_buf[i] = 8'h00;
    check_buf(32, "mid_rst");
    run_scan(1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end

endmodule
